laca_share_ctrl: RTL and testbench
==================================

Name: laca_share_ctrl

Overview:
Shares one combinational laca_4_bit slice between two requesters and sequences wide additions through it one nibble per cycle, LSB nibble first.
The carry ripples between cycles through a registered carry bit.
A round-robin arbiter grants the slice, and a valid/ready handshake returns the result.
Sits between the requesting datapaths and the single laca_4_bit instance in the arithmetic cluster.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES (16 by default); legal range 1..16.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_a  input  W  requester 0 operand A.
req0_b  input  W  requester 0 operand B.
req0_cin  input  1  requester 0 carry-in.
req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as above, for requester 1.
add_n1  output  4  to laca_4_bit n1.
add_n2  output  4  to laca_4_bit n2.
add_c0  output  1  to laca_4_bit c0.
add_sum  input  4  from laca_4_bit sum.
add_carry  input  1  from laca_4_bit carry.
resp_valid  output  1  result available.
resp_ready  input  1  consumer accepts result.
resp_id  output  1  requester that owns the result (0/1).
resp_sum  output  W  W-bit sum.
resp_cout  output  1  final carry-out.

Behaviour:
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values:
  - resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0.
  - add_n1=0, add_n2=0, add_c0=0.
  - req0_ready=req1_ready=0 while rst=1.
  - nibble index k=0, carry register=0, last_grant=1 (so req0 wins the first tie).
- IDLE, arbitration:
  - reqX_ready is combinational.
  - Exactly one ready is high, and only when that requester's valid is high.
  - If only one requester is valid, it is granted.
  - If both are valid, the one not equal to last_grant is granted.
- IDLE, accept: on valid&&ready, register a, b, cin and the id; set last_grant=id, k=0, go to RUN.
- RUN, per cycle k:
  - add_n1=a[4k+:4], add_n2=b[4k+:4].
  - add_c0 = cin when k=0, else the carry register.
  - The adder is combinational; add_sum is captured into result nibble k and add_carry into the carry register at the same edge.
  - k increments each cycle.
- RUN, exit: after k=NIBBLES-1 is captured, go to DONE with resp_cout = the last carry.
- Adder drive outside RUN: add_* are driven 0.
- DONE:
  - resp_valid=1; resp_id, resp_sum and resp_cout are held stable until resp_ready=1.
  - On resp_valid&&resp_ready, go to IDLE and drop resp_valid next cycle.
  - Both req_ready stay low in DONE, so no accept occurs in the handshake cycle.
- Latency: accept edge at cycle T gives resp_valid=1 in cycle T+NIBBLES+1.
- Throughput: minimum NIBBLES+2 cycles per operation with resp_ready tied high.
- Starvation-free: with both requesters continuously valid, grants strictly alternate.
- Requester contract: a requester may change operands or deassert valid freely before acceptance; operands are sampled only at the accept edge.
- Arithmetic: unsigned modulo 2^W; {resp_cout, resp_sum} = a + b + cin exactly.
- Reset mid-RUN or mid-DONE: the operation is aborted, no response is produced, and all state returns to the reset values. last_grant returns to 1.

Decomposition:
- Shared package/header: STATE_IDLE/RUN/DONE encodings, NIBBLE_W=4, ID_W=1.
- One natural sub-module, laca_rr_arb2: 2-way round-robin grant from two valids plus last_grant, with no state of its own; last_grant lives in the controller.
- laca_4_bit is instantiated by the enclosing top level, not inside this block.

Test Plan:
- req0: a=0xFFFF, b=0x0001, cin=0, NIBBLES=4 -> resp_sum=0x0000, resp_cout=1, resp_id=0; resp_valid first high 5 cycles after the accept edge.
- req1: a=0x1234, b=0x4321, cin=1 -> resp_sum=0x5556, resp_cout=0, resp_id=1; add_c0=1 only at k=0.
- Both requesters valid from reset, resp_ready=1:
  - grant order is req0, req1, req0, req1;
  - resp_id sequence is 0,1,0,1;
  - a new accept occurs every 6 cycles.
- resp_ready held low 3 cycles in DONE -> resp_valid, resp_sum and resp_id are stable, req0_ready=req1_ready=0; accept resumes the cycle after the handshake.
- rst pulsed during RUN at k=2 -> resp_valid never asserts for that operation and add_*=0 after reset; a following req1 operation 0x00FF+0x0001 gives 0x0100, cout 0.
- Exhaustive sweep with NIBBLES=1: all a,b in 0..15 and cin in 0..1 -> {cout,sum}=a+b+cin for all 512 cases.

Source files
------------

// File: rtl/laca_share_ctrl_pkg.sv
// Shared types and constants for the time-multiplexed nibble adder controller.
package laca_share_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned ID_W     = 1;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_RUN  = 2'd1,
        STATE_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/laca_share_ctrl_if.sv
// Request, response and adder-slice signals of laca_share_ctrl as one bundle.
interface laca_share_ctrl_if #(
    parameter int unsigned NIBBLES = 4
);
    import laca_share_ctrl_pkg::*;

    localparam int unsigned W = NIBBLE_W * NIBBLES;

    logic                req0_valid;
    logic                req0_ready;
    logic [W-1:0]        req0_a;
    logic [W-1:0]        req0_b;
    logic                req0_cin;
    logic                req1_valid;
    logic                req1_ready;
    logic [W-1:0]        req1_a;
    logic [W-1:0]        req1_b;
    logic                req1_cin;
    logic [NIBBLE_W-1:0] add_n1;
    logic [NIBBLE_W-1:0] add_n2;
    logic                add_c0;
    logic [NIBBLE_W-1:0] add_sum;
    logic                add_carry;
    logic                resp_valid;
    logic                resp_ready;
    logic [ID_W-1:0]     resp_id;
    logic [W-1:0]        resp_sum;
    logic                resp_cout;

    // Controller side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  add_sum, add_carry, resp_ready,
        output req0_ready, req1_ready,
        output add_n1, add_n2, add_c0,
        output resp_valid, resp_id, resp_sum, resp_cout
    );

    // Requesters, consumer and adder slice side
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output add_sum, add_carry, resp_ready,
        input  req0_ready, req1_ready,
        input  add_n1, add_n2, add_c0,
        input  resp_valid, resp_id, resp_sum, resp_cout
    );

endinterface

// File: rtl/laca_rr_arb2.sv
// Stateless 2-way round-robin grant; the requester that did not win last time wins a tie.
module laca_rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt0_c,
    output logic gnt1_c
);

    always_comb begin
        gnt0_c = valid0 & (~valid1 | last_grant);
        gnt1_c = valid1 & (~valid0 | ~last_grant);
    end

endmodule

// File: rtl/laca_share_ctrl.sv
// Shares one 4-bit adder slice between two requesters, rippling a wide add
// through it one nibble per cycle with the carry held in a register.
module laca_share_ctrl
    import laca_share_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    laca_share_ctrl_if.slave  bus
);

    localparam int unsigned W      = NIBBLE_W * NIBBLES;
    localparam int unsigned K_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NIBBLES - 1);

    state_e          state_q, state_d;
    logic [K_W-1:0]  k_q, k_d;
    logic            carry_q, carry_d;
    logic            last_grant_q, last_grant_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            cin_q, cin_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            resp_valid_q, resp_valid_d;

    logic            gnt0_c, gnt1_c;
    logic            ready0_c, ready1_c;
    logic [NIBBLE_W-1:0] add_n1_c, add_n2_c;
    logic            add_c0_c;
    int unsigned     nib_lsb;

    laca_rr_arb2 u_arb (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant_q),
        .gnt0_c     (gnt0_c),
        .gnt1_c     (gnt1_c)
    );

    // Next-state, operand capture and per-nibble adder drive
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        carry_d      = carry_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        sum_d        = sum_q;
        cout_d       = cout_q;
        resp_valid_d = resp_valid_q;
        ready0_c     = 1'b0;
        ready1_c     = 1'b0;
        add_n1_c     = '0;
        add_n2_c     = '0;
        add_c0_c     = 1'b0;
        nib_lsb      = NIBBLE_W * 32'(k_q);

        case (state_q)
            STATE_IDLE: begin
                ready0_c = gnt0_c & ~rst;
                ready1_c = gnt1_c & ~rst;
                if (ready0_c | ready1_c) begin
                    id_d         = ID_W'(ready1_c);
                    last_grant_d = ready1_c;
                    a_d          = ready1_c ? bus.req1_a   : bus.req0_a;
                    b_d          = ready1_c ? bus.req1_b   : bus.req0_b;
                    cin_d        = ready1_c ? bus.req1_cin : bus.req0_cin;
                    k_d          = '0;
                    state_d      = STATE_RUN;
                end
            end
            STATE_RUN: begin
                add_n1_c = NIBBLE_W'(a_q >> nib_lsb);
                add_n2_c = NIBBLE_W'(b_q >> nib_lsb);
                add_c0_c = (k_q == '0) ? cin_q : carry_q;
                sum_d    = (sum_q & ~(W'({NIBBLE_W{1'b1}}) << nib_lsb))
                         | (W'(bus.add_sum) << nib_lsb);
                carry_d  = bus.add_carry;
                k_d      = K_W'(k_q + 1'b1);
                if (k_q == K_LAST) begin
                    cout_d       = bus.add_carry;
                    resp_valid_d = 1'b1;
                    state_d      = STATE_DONE;
                end
            end
            STATE_DONE: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = STATE_IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= STATE_IDLE;
            k_q          <= '0;
            carry_q      <= 1'b0;
            last_grant_q <= 1'b1;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            sum_q        <= '0;
            cout_q       <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            carry_q      <= carry_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            sum_q        <= sum_d;
            cout_q       <= cout_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign bus.req0_ready = ready0_c;
    assign bus.req1_ready = ready1_c;
    assign bus.add_n1     = add_n1_c;
    assign bus.add_n2     = add_n2_c;
    assign bus.add_c0     = add_c0_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = sum_q;
    assign bus.resp_cout  = cout_q;

endmodule

// File: tb/tb_laca_share_ctrl.sv
// Scoreboard bench for laca_share_ctrl: a 16-bit instance under directed and
// random traffic, plus a 4-bit instance swept over every operand combination.
module tb_laca_share_ctrl;
    import laca_share_ctrl_pkg::*;

    localparam int N4 = 4;

    logic clk = 1'b0;
    logic rst;
    logic rst1;
    always #5 clk = ~clk;

    laca_share_ctrl_if #(.NIBBLES(4)) if4 ();
    laca_share_ctrl_if #(.NIBBLES(1)) if1 ();

    laca_share_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst),  .bus(if4));
    laca_share_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));

    // Behavioural 4-bit adder slices
    assign {if4.add_carry, if4.add_sum} = 5'(if4.add_n1) + 5'(if4.add_n2) + 5'(if4.add_c0);
    assign {if1.add_carry, if1.add_sum} = 5'(if1.add_n1) + 5'(if1.add_n2) + 5'(if1.add_c0);

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic id; logic [16:0] res; int due; } exp_t;
    typedef struct { logic id; int cyc; } acc_t;
    exp_t        q4[$];
    acc_t        acc_log[$];
    logic [4:0]  q1[$];

    bit          busy = 1'b0;
    bit          last_g = 1'b1;
    int          acc_cyc = 0;
    logic [16:0] acc_a, acc_b;
    logic        acc_cin;
    bit          vprev4 = 1'b0;
    logic [15:0] last_sum4;
    logic        last_cout4, last_id4;
    bit          sweep_done = 1'b0;

    // Accept monitor: arbitration model, adder-drive model, pushes expected results
    always @(negedge clk) begin
        logic e0, e1;
        int j;
        logic [16:0] mask, lo;
        if (rst) begin
            chk("rst_ready", 64'({if4.req1_ready, if4.req0_ready}), 64'd0);
            busy   = 1'b0;
            last_g = 1'b1;
        end else begin
            e0 = !busy && if4.req0_valid && (!if4.req1_valid || last_g);
            e1 = !busy && if4.req1_valid && !e0;
            chk("ready", 64'({if4.req1_ready, if4.req0_ready}), 64'({e1, e0}));
            if (busy && cyc > acc_cyc && cyc <= acc_cyc + N4) begin
                j    = cyc - acc_cyc - 1;
                mask = (17'd1 << (4 * j)) - 17'd1;
                lo   = (acc_a & mask) + (acc_b & mask) + 17'(acc_cin);
                chk("add_n1", 64'(if4.add_n1), 64'(4'(acc_a >> (4 * j))));
                chk("add_n2", 64'(if4.add_n2), 64'(4'(acc_b >> (4 * j))));
                chk("add_c0", 64'(if4.add_c0), 64'(lo[4 * j]));
            end else begin
                chk("add_idle", 64'({if4.add_n1, if4.add_n2, if4.add_c0}), 64'd0);
            end
            if (busy && if4.resp_valid && if4.resp_ready) busy = 1'b0;
            if (e0 || e1) begin
                busy    = 1'b1;
                acc_cyc = cyc;
                last_g  = e1;
                acc_a   = 17'(e1 ? if4.req1_a : if4.req0_a);
                acc_b   = 17'(e1 ? if4.req1_b : if4.req0_b);
                acc_cin = e1 ? if4.req1_cin : if4.req0_cin;
                q4.push_back('{e1, acc_a + acc_b + 17'(acc_cin), cyc + N4 + 1});
                acc_log.push_back('{e1, cyc});
            end
        end
    end

    // Response monitor: pops and compares whenever the DUT presents a result
    always @(negedge clk) begin
        if (rst) begin
            q4.delete();
            vprev4 = 1'b0;
        end else begin
            if (if4.resp_valid) begin
                if (q4.size() == 0) begin
                    chk("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    if (!vprev4) chk("resp_latency", 64'(cyc), 64'(q4[0].due));
                    chk("resp_id",   64'(if4.resp_id),   64'(q4[0].id));
                    chk("resp_sum",  64'(if4.resp_sum),  64'(q4[0].res[15:0]));
                    chk("resp_cout", 64'(if4.resp_cout), 64'(q4[0].res[16]));
                    if (if4.resp_ready) begin
                        last_sum4  = if4.resp_sum;
                        last_cout4 = if4.resp_cout;
                        last_id4   = if4.resp_id;
                        void'(q4.pop_front());
                    end
                end
            end else if (q4.size() != 0 && cyc >= q4[0].due) begin
                chk("resp_late", 64'd0, 64'd1);
            end
            vprev4 = if4.resp_valid && !if4.resp_ready;
        end
    end

    // Response monitor for the 4-bit instance
    always @(negedge clk) begin
        if (!rst1 && if1.resp_valid && if1.resp_ready) begin
            if (q1.size() == 0) chk("sweep_unexpected", 64'd1, 64'd0);
            else begin
                chk("sweep_id", 64'(if1.resp_id), 64'd0);
                chk("sweep_sum", 64'({if1.resp_cout, if1.resp_sum}), 64'(q1.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit id, input bit v, input logic [15:0] a, b, input logic cin);
        if (id) begin
            if4.req1_valid = v; if4.req1_a = a; if4.req1_b = b; if4.req1_cin = cin;
        end else begin
            if4.req0_valid = v; if4.req0_a = a; if4.req0_b = b; if4.req0_cin = cin;
        end
    endtask

    task automatic op(input bit id, input logic [15:0] a, b, input logic cin);
        int t;
        set_req(id, 1'b1, a, b, cin);
        t = 0;
        @(negedge clk);
        while (!(id ? if4.req1_ready : if4.req0_ready) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("accept_timeout", 64'(t), 64'd0);
        tick();
        set_req(id, 1'b0, 16'(0), 16'(0), 1'b0);
    endtask

    task automatic wait_resp();
        int t;
        t = 0;
        @(negedge clk);
        while (!(if4.resp_valid && if4.resp_ready) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("resp_timeout", 64'(t), 64'd0);
        tick();
    endtask

    // 4-bit instance: exhaustive operand sweep with valid held high
    initial begin
        int t;
        rst1 = 1'b1;
        if1.req0_valid = 1'b0; if1.req0_a = '0; if1.req0_b = '0; if1.req0_cin = 1'b0;
        if1.req1_valid = 1'b0; if1.req1_a = '0; if1.req1_b = '0; if1.req1_cin = 1'b0;
        if1.resp_ready = 1'b1;
        repeat (3) tick();
        rst1 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    if1.req0_valid = 1'b1;
                    if1.req0_a     = 4'(a);
                    if1.req0_b     = 4'(b);
                    if1.req0_cin   = 1'(c);
                    t = 0;
                    @(negedge clk);
                    while (!if1.req0_ready && t < 10) begin
                        @(negedge clk);
                        t++;
                    end
                    if (t >= 10) chk("sweep_accept_timeout", 64'(t), 64'd0);
                    q1.push_back(5'(a + b + c));
                    tick();
                end
            end
        end
        if1.req0_valid = 1'b0;
        repeat (6) tick();
        chk("sweep_drain", 64'(q1.size()), 64'd0);
        sweep_done = 1'b1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // 16-bit instance: directed scenarios followed by random traffic
    initial begin
        int t;
        int hs_cyc;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 16'(0), 16'(0), 1'b0);
        set_req(1'b1, 1'b0, 16'(0), 16'(0), 1'b0);
        if4.resp_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_resp", 64'({if4.resp_valid, if4.resp_id, if4.resp_sum, if4.resp_cout}), 64'd0);
        chk("reset_add",  64'({if4.add_n1, if4.add_n2, if4.add_c0}), 64'd0);
        tick();
        rst = 1'b0;

        op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        wait_resp();
        chk("A_sum",  64'(last_sum4),  64'h0000);
        chk("A_cout", 64'(last_cout4), 64'd1);
        chk("A_id",   64'(last_id4),   64'd0);

        op(1'b1, 16'h1234, 16'h4321, 1'b1);
        wait_resp();
        chk("B_sum",  64'(last_sum4),  64'h5556);
        chk("B_cout", 64'(last_cout4), 64'd0);
        chk("B_id",   64'(last_id4),   64'd1);

        // Both requesters continuously valid from reset
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        acc_log.delete();
        t = 0;
        while (acc_log.size() < 4 && t < 60) begin
            set_req(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            set_req(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            tick();
            t++;
        end
        set_req(1'b0, 1'b0, 16'(0), 16'(0), 1'b0);
        set_req(1'b1, 1'b0, 16'(0), 16'(0), 1'b0);
        wait_resp();
        chk("alt_count", 64'(acc_log.size()), 64'd4);
        for (int i = 0; i < acc_log.size() && i < 4; i++) begin
            chk("alt_id", 64'(acc_log[i].id), 64'(i % 2));
            if (i > 0) chk("alt_gap", 64'(acc_log[i].cyc - acc_log[i-1].cyc), 64'd6);
        end

        // Consumer stalls for three cycles while req1 waits
        if4.resp_ready = 1'b0;
        op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        set_req(1'b1, 1'b1, 16'h0F0F, 16'hF0F1, 1'b0);
        t = 0;
        @(negedge clk);
        while (!if4.resp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("stall_timeout", 64'(t), 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_valid", 64'(if4.resp_valid), 64'd1);
            chk("stall_ready", 64'({if4.req1_ready, if4.req0_ready}), 64'd0);
        end
        tick();
        if4.resp_ready = 1'b1;
        @(negedge clk);
        hs_cyc = cyc;
        chk("hs_ready", 64'({if4.req1_ready, if4.req0_ready}), 64'd0);
        acc_log.delete();
        @(negedge clk);
        chk("resume_ready", 64'(if4.req1_ready), 64'd1);
        chk("resume_cycle", 64'(cyc - hs_cyc), 64'd1);
        tick();
        set_req(1'b1, 1'b0, 16'(0), 16'(0), 1'b0);
        wait_resp();
        chk("resume_sum", 64'({last_cout4, last_sum4}), 64'h1_0000);

        // Reset while the third nibble is in flight
        op(1'b0, 16'hABCD, 16'h1111, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_add", 64'({if4.add_n1, if4.add_n2, if4.add_c0}), 64'd0);
        for (int i = 0; i < 8; i++) begin
            chk("abort_no_resp", 64'(if4.resp_valid), 64'd0);
            @(negedge clk);
        end
        tick();
        op(1'b1, 16'h00FF, 16'h0001, 1'b0);
        wait_resp();
        chk("E_sum",  64'(last_sum4),  64'h0100);
        chk("E_cout", 64'(last_cout4), 64'd0);
        chk("E_id",   64'(last_id4),   64'd1);

        // Random valids, operands and consumer back-pressure
        for (int i = 0; i < 400; i++) begin
            set_req(1'b0, 1'(($urandom % 3) == 0), 16'($urandom), 16'($urandom), 1'($urandom));
            set_req(1'b1, 1'(($urandom % 3) == 0), 16'($urandom), 16'($urandom), 1'($urandom));
            if4.resp_ready = 1'(($urandom % 4) != 0);
            tick();
        end
        set_req(1'b0, 1'b0, 16'(0), 16'(0), 1'b0);
        set_req(1'b1, 1'b0, 16'(0), 16'(0), 1'b0);
        if4.resp_ready = 1'b1;
        repeat (12) tick();
        chk("random_drain", 64'(q4.size()), 64'd0);

        t = 0;
        while (!sweep_done && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) chk("sweep_timeout", 64'(t), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
